// File: rtl/alu_operand_seq.sv
// -----------------------------------------------------------------------------
// alu_operand_seq
//
// Purpose: front-panel operand sequencer for a 4-bit ALU stage. Two raw push
// buttons are synchronized and debounced. "next" captures operand A, then
// operand B, then opcode + carry-in. The captured operation is then presented
// to the downstream ALU stage until it is accepted. "clr" aborts an entry at
// any point.
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   rst        in   asynchronous active-high reset
//   btn_next   in   raw capture/advance button (asynchronous)
//   btn_clr    in   raw abort button (asynchronous)
//   sw_data    in   [3:0] operand value for A or B
//   sw_op      in   [2:0] opcode
//   sw_cin     in   carry-in, captured together with the opcode
//   out_ready  in   downstream ALU stage accepts the current operation
//   a, b       out  [3:0] registered operands
//   op         out  [2:0] registered opcode
//   cin        out  registered carry-in
//   out_valid  out  operation presented to the ALU stage
//   stage      out  [1:0] current FSM state (LED display / debug)
//   txn_count  out  [3:0] completed handshakes, modulo 16
//
// Handshake: out_valid is a register that is 1 exactly while the FSM is in
// S_ISSUE. A transfer completes on a rising edge where out_valid and
// out_ready are both 1. While out_valid is 1, a/b/op/cin do not change.
// out_ready is ignored whenever out_valid is 0.
// -----------------------------------------------------------------------------
module alu_operand_seq #(
   parameter logic [15:0] DEBOUNCE_CNT = 16'd50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_next,
   input  logic       btn_clr,
   input  logic [3:0] sw_data,
   input  logic [2:0] sw_op,
   input  logic       sw_cin,
   input  logic       out_ready,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic [2:0] op,
   output logic       cin,
   output logic       out_valid,
   output logic [1:0] stage,
   output logic [3:0] txn_count
);

   typedef enum logic [1:0] {
      S_A     = 2'b00,
      S_B     = 2'b01,
      S_OP    = 2'b10,
      S_ISSUE = 2'b11
   } state_t;

   // Button conditioning registers
   logic        r_next_s1, r_next_s2, r_next_db, r_next_db_q;
   logic        r_clr_s1, r_clr_s2, r_clr_db, r_clr_db_q;
   logic [15:0] r_next_cnt, r_clr_cnt;

   // Datapath / FSM registers
   state_t      r_state;
   logic [3:0]  r_a, r_b, r_txn;
   logic [2:0]  r_op;
   logic        r_cin, r_out_valid;

   // Combinational control
   logic        w_next_hit, w_clr_hit;
   logic        w_next_press, w_clr_press;
   logic        w_xfer;
   state_t      w_state_nxt;
   logic        w_load_a, w_load_b, w_load_op, w_clear;

   // The debounced level flips on the edge where the counter would reach
   // DEBOUNCE_CNT; the counter never exceeds DEBOUNCE_CNT-1, so +1 cannot
   // overflow 16 bits.
   assign w_next_hit = (r_next_cnt + 16'd1) == DEBOUNCE_CNT;
   assign w_clr_hit  = (r_clr_cnt  + 16'd1) == DEBOUNCE_CNT;

   // Press pulse: the first cycle in which the debounced level reads 1.
   assign w_next_press = r_next_db & ~r_next_db_q;
   assign w_clr_press  = r_clr_db  & ~r_clr_db_q;

   assign w_xfer = r_out_valid & out_ready;

   // 2-flop synchronizers and debounce counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_next_s1   <= 1'b0;
         r_next_s2   <= 1'b0;
         r_next_db   <= 1'b0;
         r_next_db_q <= 1'b0;
         r_next_cnt  <= 16'd0;
         r_clr_s1    <= 1'b0;
         r_clr_s2    <= 1'b0;
         r_clr_db    <= 1'b0;
         r_clr_db_q  <= 1'b0;
         r_clr_cnt   <= 16'd0;
      end else begin
         r_next_s1   <= btn_next;
         r_next_s2   <= r_next_s1;
         r_next_db_q <= r_next_db;
         r_clr_s1    <= btn_clr;
         r_clr_s2    <= r_clr_s1;
         r_clr_db_q  <= r_clr_db;

         if (r_next_s2 == r_next_db) begin
            r_next_cnt <= 16'd0;
         end else if (w_next_hit) begin
            r_next_db  <= ~r_next_db;
            r_next_cnt <= 16'd0;
         end else begin
            r_next_cnt <= r_next_cnt + 16'd1;
         end

         if (r_clr_s2 == r_clr_db) begin
            r_clr_cnt <= 16'd0;
         end else if (w_clr_hit) begin
            r_clr_db  <= ~r_clr_db;
            r_clr_cnt <= 16'd0;
         end else begin
            r_clr_cnt <= r_clr_cnt + 16'd1;
         end
      end
   end

   // FSM next-state and load decode. Clear wins over a simultaneous next.
   always_comb begin
      w_state_nxt = r_state;
      w_load_a    = 1'b0;
      w_load_b    = 1'b0;
      w_load_op   = 1'b0;
      w_clear     = 1'b0;
      if (w_clr_press) begin
         w_state_nxt = S_A;
         w_clear     = 1'b1;
      end else begin
         case (r_state)
            S_A: if (w_next_press) begin
               w_load_a    = 1'b1;
               w_state_nxt = S_B;
            end
            S_B: if (w_next_press) begin
               w_load_b    = 1'b1;
               w_state_nxt = S_OP;
            end
            S_OP: if (w_next_press) begin
               w_load_op   = 1'b1;
               w_state_nxt = S_ISSUE;
            end
            S_ISSUE: if (w_xfer) begin
               w_state_nxt = S_A;
            end
            default: w_state_nxt = S_A;
         endcase
      end
   end

   // FSM state, operand registers, valid flag and transfer counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_A;
         r_a         <= 4'd0;
         r_b         <= 4'd0;
         r_op        <= 3'd0;
         r_cin       <= 1'b0;
         r_out_valid <= 1'b0;
         r_txn       <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= (w_state_nxt == S_ISSUE);
         // A transfer completing alongside a clear is still counted.
         if (w_xfer) r_txn <= r_txn + 4'd1;
         if (w_clear) begin
            r_a   <= 4'd0;
            r_b   <= 4'd0;
            r_op  <= 3'd0;
            r_cin <= 1'b0;
         end else begin
            if (w_load_a) r_a <= sw_data;
            if (w_load_b) r_b <= sw_data;
            if (w_load_op) begin
               r_op  <= sw_op;
               r_cin <= sw_cin;
            end
         end
      end
   end

   assign a         = r_a;
   assign b         = r_b;
   assign op        = r_op;
   assign cin       = r_cin;
   assign out_valid = r_out_valid;
   assign stage     = r_state;
   assign txn_count = r_txn;

endmodule

// File: tb/tb_alu_operand_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_seq
//
// Directed bench for alu_operand_seq with DEBOUNCE_CNT=4. Outputs are sampled
// on the falling edge (or 1 time unit after a rising edge) and compared with
// hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_alu_operand_seq;

   logic       clk;
   logic       rst;
   logic       btn_next;
   logic       btn_clr;
   logic [3:0] sw_data;
   logic [2:0] sw_op;
   logic       sw_cin;
   logic       out_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic [2:0] op;
   logic       cin;
   logic       out_valid;
   logic [1:0] stage;
   logic [3:0] txn_count;

   int errors = 0;
   int checks = 0;
   int exp_txn = 0;

   alu_operand_seq #(.DEBOUNCE_CNT(16'd4)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_next  (btn_next),
      .btn_clr   (btn_clr),
      .sw_data   (sw_data),
      .sw_op     (sw_op),
      .sw_cin    (sw_cin),
      .out_ready (out_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .cin       (cin),
      .out_valid (out_valid),
      .stage     (stage),
      .txn_count (txn_count)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Hold the chosen buttons for 10 cycles, then release and let the
   // release debounce settle. Ends on a falling edge.
   task automatic press(input logic p_next, input logic p_clr);
      @(negedge clk);
      btn_next = p_next;
      btn_clr  = p_clr;
      repeat (10) @(negedge clk);
      btn_next = 1'b0;
      btn_clr  = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      btn_next  = 1'b0;
      btn_clr   = 1'b0;
      sw_data   = 4'h0;
      sw_op     = 3'b000;
      sw_cin    = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_stage", 32'(stage), 32'd0);
      check("rst_a", 32'(a), 32'd0);
      check("rst_b", 32'(b), 32'd0);
      check("rst_op", 32'(op), 32'd0);
      check("rst_cin", 32'(cin), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_txn", 32'(txn_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single press, exact latency: debounced at edge 6, FSM moves at edge 7
      sw_data  = 4'h5;
      btn_next = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("lat_stage_e6", 32'(stage), 32'd0);
      @(posedge clk);
      #1 check("lat_stage_e7", 32'(stage), 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      btn_next = 1'b0;
      repeat (12) @(negedge clk);
      check("one_press_stage", 32'(stage), 32'd1);
      check("one_press_a", 32'(a), 32'h5);

      // Glitch shorter than the debounce window
      sw_data  = 4'hA;
      btn_next = 1'b1;
      repeat (3) @(negedge clk);
      btn_next = 1'b0;
      repeat (12) @(negedge clk);
      check("glitch_stage", 32'(stage), 32'd1);
      check("glitch_b", 32'(b), 32'h0);

      // Capture B, then opcode, hold with out_ready low
      press(1'b1, 1'b0);
      check("capb_stage", 32'(stage), 32'd2);
      check("capb_b", 32'(b), 32'hA);
      sw_op  = 3'b001;
      sw_cin = 1'b0;
      press(1'b1, 1'b0);
      check("issue_stage", 32'(stage), 32'd3);
      check("issue_valid", 32'(out_valid), 32'd1);
      check("issue_a", 32'(a), 32'h5);
      check("issue_b", 32'(b), 32'hA);
      check("issue_op", 32'(op), 32'd1);
      check("issue_cin", 32'(cin), 32'd0);
      repeat (5) @(negedge clk);
      check("issue_hold_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_txn++;
      check("xfer_valid", 32'(out_valid), 32'd0);
      check("xfer_stage", 32'(stage), 32'd0);
      check("xfer_txn", 32'(txn_count), 32'(exp_txn % 16));
      check("xfer_a_kept", 32'(a), 32'h5);

      // Clear and next together while in S_OP
      sw_data = 4'h3;
      press(1'b1, 1'b0);
      sw_data = 4'h4;
      press(1'b1, 1'b0);
      check("pre_clr_stage", 32'(stage), 32'd2);
      press(1'b1, 1'b1);
      check("clr_stage", 32'(stage), 32'd0);
      check("clr_a", 32'(a), 32'h0);
      check("clr_b", 32'(b), 32'h0);
      check("clr_op", 32'(op), 32'h0);
      check("clr_txn", 32'(txn_count), 32'(exp_txn % 16));

      // Extra next-press while issuing is ignored
      sw_data = 4'h9;
      press(1'b1, 1'b0);
      sw_data = 4'h6;
      press(1'b1, 1'b0);
      sw_op  = 3'b101;
      sw_cin = 1'b1;
      press(1'b1, 1'b0);
      sw_data = 4'hF;
      press(1'b1, 1'b0);
      check("ign_stage", 32'(stage), 32'd3);
      check("ign_a", 32'(a), 32'h9);
      check("ign_op", 32'(op), 32'd5);
      check("ign_cin", 32'(cin), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_txn++;
      check("ign_txn", 32'(txn_count), 32'(exp_txn % 16));

      // Remaining transfers with out_ready tied high until the counter wraps
      out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         sw_data = 4'(i);
         press(1'b1, 1'b0);
         press(1'b1, 1'b0);
         press(1'b1, 1'b0);
         exp_txn++;
      end
      check("wrap_stage", 32'(stage), 32'd0);
      check("wrap_txn", 32'(txn_count), 32'(exp_txn % 16));
      check("wrap_txn_zero", 32'(txn_count), 32'd0);
      out_ready = 1'b0;

      // One more transfer so the counter is nonzero before the reset test
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_txn++;
      check("pre_rst_txn", 32'(txn_count), 32'(exp_txn % 16));

      // Asynchronous reset between clock edges while issuing
      sw_data = 4'h7;
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      check("pre_rst_stage", 32'(stage), 32'd3);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_stage", 32'(stage), 32'd0);
      check("arst_txn", 32'(txn_count), 32'd0);
      check("arst_a", 32'(a), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_stage", 32'(stage), 32'd0);
      check("post_rst_valid", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time limit so the bench always ends on its own
   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "time limit reached");
   end

endmodule
